// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// Bit timing is derived from the system clock with a 16-bit down-counter.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        tx,
    output logic        busy,
    output logic [1:0]  grant_id
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);

    state_t      state_reg,    state_next;
    logic [15:0] bit_cnt_reg,  bit_cnt_next;
    logic [2:0]  idx_reg,      idx_next;
    logic [1:0]  rr_ptr_reg,   rr_ptr_next;
    logic [1:0]  grant_id_reg, grant_id_next;
    logic [7:0]  shift_reg,    shift_next;
    logic        tx_reg,       tx_next;
    logic        busy_reg,     busy_next;

    logic [7:0]  req_byte [4];
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic        accept;
    logic        bit_done;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Rotating-priority search: the first valid requester at or after rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr_reg;
        cand        = rr_ptr_reg;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_reg + k[1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept   = (state_reg == IDLE) && grant_found;
    assign bit_done = (bit_cnt_reg == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 16'd0;
            idx_reg      <= 3'd0;
            rr_ptr_reg   <= 2'd0;
            grant_id_reg <= 2'd0;
            shift_reg    <= 8'd0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            idx_reg      <= idx_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_id_reg <= grant_id_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
        end
    end

    // tx is registered, so the level for the upcoming bit is chosen at each boundary.
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        idx_next      = idx_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_id_next = grant_id_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        busy_next     = busy_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    shift_next    = req_byte[grant_idx];
                    grant_id_next = grant_idx;
                    rr_ptr_next   = grant_idx + 2'd1;
                    bit_cnt_next  = BIT_LOAD;
                    state_next    = START;
                    tx_next       = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    idx_next     = 3'd0;
                    bit_cnt_next = BIT_LOAD;
                    tx_next      = shift_reg[0];
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_next = BIT_LOAD;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        tx_next  = shift_reg[idx_reg + 3'd1];
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 4'b0000;
        if (accept) begin
            req_ready = 4'b0001 << grant_idx;
        end
    end

    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Drives two arbiters (4 and 2 clocks per bit) with shared stimulus and checks them
// against a frame-level model: grant order, serial waveform, busy and grant_id.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'd0;

    logic [3:0]  ready_w [2];
    logic        tx_w    [2];
    logic        busy_w  [2];
    logic [1:0]  gid_w   [2];

    uart_tx_arbiter #(.CLKS_PER_BIT(4)) dut_n4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .grant_id(gid_w[0])
    );

    uart_tx_arbiter #(.CLKS_PER_BIT(2)) dut_n2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .grant_id(gid_w[1])
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         p;
    int         e0     [2];
    bit         active [2];
    logic [7:0] fbyte  [2];
    int         ptr    [2];
    int         gid    [2];
    int         mode;
    bit         rand_data;
    logic [3:0] fix_valid;
    logic [31:0] fix_data;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at edge %0d", tag, got, exp, p);
        end
    endtask

    function automatic int nb(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic bit in_frame(input int i);
        return active[i] && (p >= e0[i]) && (p < e0[i] + 10*nb(i));
    endfunction

    // Frame = start(0), data LSB first, stop(1); each symbol lasts nb(i) cycles from E0.
    function automatic int exp_tx(input int i);
        int b;
        if (!in_frame(i)) return 1;
        b = (p - e0[i]) / nb(i);
        if (b == 0) return 0;
        if (b == 9) return 1;
        return int'(fbyte[i][b-1]);
    endfunction

    task automatic model_reset();
        p = 0;
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0;
            e0[i]     = 0;
            ptr[i]    = 0;
            gid[i]    = 0;
        end
    endtask

    task automatic step();
        int  q;
        int  win;
        int  c;
        bit  idle;
        int  exp_r;
        case (mode)
            0: req_valid = fix_valid;
            1: req_valid = 4'($urandom) & 4'($urandom);
            default: req_valid = {2'b00, 1'($urandom), 1'b0};
        endcase
        req_data = rand_data ? $urandom : fix_data;
        #1;
        for (int i = 0; i < 2; i++) begin
            q    = p + 1;
            idle = !active[i] || (q >= e0[i] + 10*nb(i) + 1);
            win  = -1;
            if (idle) begin
                for (int k = 0; k < 4; k++) begin
                    c = (ptr[i] + k) % 4;
                    if (win < 0 && req_valid[c]) win = c;
                end
            end
            exp_r = (win >= 0) ? (1 << win) : 0;
            check($sformatf("ready%0d", i), int'(ready_w[i]), exp_r);
            if (win >= 0) begin
                e0[i]     = q;
                fbyte[i]  = req_data[win*8 +: 8];
                ptr[i]    = (win + 1) % 4;
                gid[i]    = win;
                active[i] = 1'b1;
                $display("grant dut%0d req=%0d byte=%02h edge=%0d", i, win, fbyte[i], q);
            end
        end
        p++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("tx%0d", i),   int'(tx_w[i]),   exp_tx(i));
            check($sformatf("busy%0d", i), int'(busy_w[i]), int'(in_frame(i)));
            check($sformatf("gid%0d", i),  int'(gid_w[i]),  gid[i]);
        end
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic fixed(input logic [3:0] v, input logic [31:0] d, input int n);
        mode = 0; rand_data = 1'b0; fix_valid = v; fix_data = d;
        run(n);
    endtask

    initial begin
        bit reached;
        mode = 0; rand_data = 1'b0; fix_valid = 4'b0000; fix_data = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_tx%0d", i),   int'(tx_w[i]),   1);
            check($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
            check($sformatf("rst_gid%0d", i),  int'(gid_w[i]),  0);
        end
        rst_n = 1'b1;

        fixed(4'b0001, 32'h000000A5, 1);
        fixed(4'b0000, 32'd0, 45);
        fixed(4'b1111, 32'h44332211, 5*41 + 5);
        fixed(4'b0000, 32'd0, 45);
        fixed(4'b0100, 32'h00CC0000, 1);
        fixed(4'b0000, 32'd0, 45);
        fixed(4'b1010, 32'h5A00C300, 90);
        fixed(4'b0000, 32'd0, 45);
        fixed(4'b0001, 32'h00000000, 1);
        mode = 2; rand_data = 1'b0; fix_data = 32'hFFFFFFFF;
        run(60);
        fixed(4'b0000, 32'd0, 45);
        fixed(4'b0001, 32'h00000080, 1);
        fixed(4'b0000, 32'd0, 45);

        mode = 1; rand_data = 1'b1;
        run(3000);
        fixed(4'b0000, 32'd0, 45);

        // Abort a frame during data bit 3 of the slower instance.
        fixed(4'b0001, 32'h000000C6, 1);
        fix_valid = 4'b0000;
        reached = 1'b0;
        for (int j = 0; j < 100 && !reached; j++) begin
            step();
            if (in_frame(0) && ((p - e0[0]) / nb(0)) == 4) reached = 1'b1;
        end
        check("reach_bit3", int'(reached), 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("async_tx%0d", i),   int'(tx_w[i]),   1);
            check($sformatf("async_busy%0d", i), int'(busy_w[i]), 0);
            check($sformatf("async_gid%0d", i),  int'(gid_w[i]),  0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fixed(4'b1000, 32'h3C000000, 1);
        fixed(4'b0000, 32'd0, 45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shared serial-transmit controller. Four independent requesters share one UART line. The block arbitrates round-robin, accepts one byte per handshake, and sequences it onto `tx` as an 8N1 frame (start bit, 8 data bits LSB first, 1 stop bit). It sits between the on-chip byte producers and the single UART pin. It generates its own bit timing from the system clock, so no separate baud clock is needed.

## Interface
- `CLKS_PER_BIT`, default 868: system clocks per serial bit. Legal values are 2 to 65535.
- `clk  input  1`: system clock. All logic is on the rising edge.
- `rst_n  input  1`: reset. Asynchronous, active-low.
- `req_valid  input  4`: bit i high means requester i has a byte to send.
- `req_data  input  32`: packed bytes. Requester i drives bits [8i+7:8i].
- `req_ready  output  4`: one-hot accept, combinational. Bit i high means requester i is granted this cycle.
- `tx  output  1`: serial line, registered. Idles high.
- `busy  output  1`: registered. High while a frame is in flight (state is not IDLE).
- `grant_id  output  2`: registered. Index of the requester whose frame is in flight, or of the last one served.

## Operation
- There are four states: IDLE, START, DATA, STOP.
- **Bit counter:** a 16-bit down-counter `bit_cnt`, loaded with CLKS_PER_BIT-1. A bit period ends when `bit_cnt` reaches 0.
- **Data counter:** a 3-bit index, 0 to 7.
- **Round-robin pointer:** `rr_ptr`, 2 bits.
- **IDLE:**
  - Search `req_valid` starting at `rr_ptr` and wrapping 3→0. The first set bit i wins.
  - `req_ready[i]` = 1 in that same cycle. All other ready bits are 0.
  - If no request is valid, `req_ready` = 0.
  - On the clock edge: latch `req_data[8i+7:8i]` into the shift register, set `grant_id`=i, set `rr_ptr`=(i+1) mod 4, load `bit_cnt`, go to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
- **DATA:** `tx`=shift[index] for CLKS_PER_BIT cycles per bit. Index counts 0 to 7. After bit 7 ends, go to STOP.
- **STOP:** `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `req_ready` is 0 in every state except IDLE.
- `req_valid` and `req_data` are ignored outside the accept cycle.
- A requester that drops `req_valid` before it is granted loses nothing.
- A requester may hold `req_valid` high across back-to-back frames. Each grant consumes exactly one byte.
- If several requests arrive at once, only one is granted. The others wait for later IDLE cycles, in rotating priority.
- The pointer only advances on a grant. Idle cycles leave it unchanged.
- **Reset values** (asynchronous, on `rst_n`=0): state=IDLE, `tx`=1, `busy`=0, `grant_id`=0, `rr_ptr`=0, `bit_cnt`=0, index=0, shift=0.
- **Reset mid-frame:** the frame is abandoned and `tx` returns to 1 immediately. After release, arbitration restarts from requester 0.

## Timing
- Let E0 be the edge at which valid&ready is sampled.
- `tx` falls and `busy` rises at E0.
- **Bit boundaries:**
  - Start bit: E0 to E0+N, where N = CLKS_PER_BIT.
  - Data bit k: E0+(k+1)N to E0+(k+2)N.
  - Stop bit: E0+9N to E0+10N.
- At E0+10N the state is IDLE and `busy`=0.
- The earliest next accept is the cycle following E0+10N, so the next frame's start bit begins at E0+10N+1.
- Back-to-back frames therefore have a stop period of exactly N+1 cycles.
- Frame length is exactly 10N cycles from E0.
- `grant_id` updates at E0 and holds until the next grant.

## Test plan
- **Single frame:** reset, CLKS_PER_BIT=4, `req_valid`=0001, byte 0xA5 → `req_ready`=0001 for one cycle. `tx` over 40 cycles: 0, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1. `busy` high for 40 cycles.
- **Contention:** all four valid, bytes 0x11/0x22/0x33/0x44 held → grants in order 0,1,2,3,0. Serial bytes 0x11,0x22,0x33,0x44,0x11. Each frame is 40 cycles with a 1-cycle extra idle between frames.
- **Fairness after idle:** serve requester 2 only, then assert valid on 1 and 3 together → requester 3 is granted first (`rr_ptr`=3), then requester 1.
- **Ignore while busy:** toggle `req_valid`=0010 with data 0xFF during an in-flight 0x00 frame → `req_ready` stays 0 and `tx` sends 0x00 unchanged. The 0xFF frame is accepted only after `busy` falls.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3 → `tx`=1 and `busy`=0 asynchronously. After release with `req_valid`=1000, requester 3 is granted and its frame starts cleanly.
- **Minimum divider:** CLKS_PER_BIT=2, byte 0x80 → 20-cycle frame. Bit 7 is high for exactly 2 cycles, at E0+16 to E0+18.
